init_reset_sequencer: RTL and testbench



---
 rtl/init_reset_sequencer.sv | 135 +++++++++++++
 tb/tb_init_reset_sequencer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/init_reset_sequencer.sv
// init_reset_sequencer: holds the user fabric in reset until device init is
// done and the PLL lock is stable. It then releases the core reset first and
// the peripheral reset a fixed gap later. Lock-loss events are counted for
// diagnostics.
//
// state     | code | meaning
// ----------+------+---------------------------------------------------------
// RST       |  0   | power-on / RESET_N low; leaves on the first edge
// WAIT_INIT |  1   | waiting for synchronised DEVICE_INIT_DONE
// WAIT_LOCK |  2   | filtering lock: needs LOCK_FILTER consecutive highs
// STRETCH   |  3   | lock qualified; holding reset for STRETCH_CYCLES
// RUN_A     |  4   | core fabric released; peripherals held for STAGE_GAP
// RUN       |  5   | both resets released; steady state
module init_reset_sequencer #(
    parameter int LOCK_FILTER    = 16,
    parameter int STRETCH_CYCLES = 64,
    parameter int STAGE_GAP      = 8
) (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic       DEVICE_INIT_DONE,
    input  logic       PLL_LOCK,
    output logic       FABRIC_RESET_N,
    output logic       PERIPH_RESET_N,
    output logic [2:0] STATE,
    output logic [7:0] LOCK_LOSS_CNT
);

    localparam int MAX_AB = (LOCK_FILTER > STRETCH_CYCLES) ? LOCK_FILTER : STRETCH_CYCLES;
    localparam int MAX_P  = (MAX_AB > STAGE_GAP) ? MAX_AB : STAGE_GAP;
    localparam int CW     = (MAX_P > 1) ? $clog2(MAX_P) : 1;

    localparam logic [CW-1:0] LF_LAST = CW'(LOCK_FILTER - 1);
    localparam logic [CW-1:0] SC_LAST = CW'(STRETCH_CYCLES - 1);
    localparam logic [CW-1:0] SG_LAST = CW'(STAGE_GAP - 1);

    typedef enum logic [2:0] {
        S_RST       = 3'd0,
        S_WAIT_INIT = 3'd1,
        S_WAIT_LOCK = 3'd2,
        S_STRETCH   = 3'd3,
        S_RUN_A     = 3'd4,
        S_RUN       = 3'd5
    } state_t;

    logic          r_init_meta, r_init_s;
    logic          r_lock_meta, r_lock_s;
    state_t        r_state, w_next;
    logic [CW-1:0] r_cnt, w_cnt_next;
    logic          r_fabric_rst_n, r_periph_rst_n;
    logic [7:0]    r_loss_cnt;
    logic          w_fault_state, w_loss;

    // Two-flop synchronisers for the asynchronous status inputs
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_init_meta <= 1'b0;
            r_init_s    <= 1'b0;
            r_lock_meta <= 1'b0;
            r_lock_s    <= 1'b0;
        end else begin
            r_init_meta <= DEVICE_INIT_DONE;
            r_init_s    <= r_init_meta;
            r_lock_meta <= PLL_LOCK;
            r_lock_s    <= r_lock_meta;
        end
    end

    // A fault can only be taken once the release sequence has started
    assign w_fault_state = (r_state == S_STRETCH) || (r_state == S_RUN_A) || (r_state == S_RUN);
    // Init loss has priority, so a lock loss only counts while init is good
    assign w_loss        = w_fault_state && r_init_s && !r_lock_s;

    // Next-state decode, fault priority, and phase counter
    always_comb begin
        w_next     = r_state;
        w_cnt_next = '0;
        case (r_state)
            S_RST:       w_next = S_WAIT_INIT;
            S_WAIT_INIT: if (r_init_s) w_next = S_WAIT_LOCK;
            S_WAIT_LOCK: begin
                if (!r_init_s)                        w_next = S_WAIT_INIT;
                else if (r_lock_s && r_cnt == LF_LAST) w_next = S_STRETCH;
            end
            S_STRETCH: begin
                if (!r_init_s)              w_next = S_WAIT_INIT;
                else if (!r_lock_s)         w_next = S_WAIT_LOCK;
                else if (r_cnt == SC_LAST)  w_next = S_RUN_A;
            end
            S_RUN_A: begin
                if (!r_init_s)              w_next = S_WAIT_INIT;
                else if (!r_lock_s)         w_next = S_WAIT_LOCK;
                else if (r_cnt == SG_LAST)  w_next = S_RUN;
            end
            S_RUN: begin
                if (!r_init_s)              w_next = S_WAIT_INIT;
                else if (!r_lock_s)         w_next = S_WAIT_LOCK;
            end
            default:                        w_next = S_RST;
        endcase

        // The counter restarts from zero on every state entry
        if (w_next == r_state) begin
            case (r_state)
                S_WAIT_LOCK:        w_cnt_next = r_lock_s ? (r_cnt + 1'b1) : '0;
                S_STRETCH, S_RUN_A: w_cnt_next = r_cnt + 1'b1;
                default:            w_cnt_next = '0;
            endcase
        end
    end

    // State, counters, and resets registered from the next-state decode
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state        <= S_RST;
            r_cnt          <= '0;
            r_fabric_rst_n <= 1'b0;
            r_periph_rst_n <= 1'b0;
            r_loss_cnt     <= 8'd0;
        end else begin
            r_state        <= w_next;
            r_cnt          <= w_cnt_next;
            r_fabric_rst_n <= (w_next == S_RUN_A) || (w_next == S_RUN);
            r_periph_rst_n <= (w_next == S_RUN);
            if (w_loss && (r_loss_cnt != 8'hFF))
                r_loss_cnt <= r_loss_cnt + 8'd1;
        end
    end

    assign FABRIC_RESET_N = r_fabric_rst_n;
    assign PERIPH_RESET_N = r_periph_rst_n;
    assign STATE          = r_state;
    assign LOCK_LOSS_CNT  = r_loss_cnt;

endmodule

// File: tb/tb_init_reset_sequencer.sv
// Testbench for init_reset_sequencer. Stimulus pushes expected snapshots
// tagged with the clock edge after which they must hold. A monitor samples
// the DUT on each falling edge and compares against the queue head.
module tb_init_reset_sequencer;

    logic       CLK = 1'b0;
    logic       RESET_N;
    logic       DEVICE_INIT_DONE;
    logic       PLL_LOCK;
    logic       FABRIC_RESET_N;
    logic       PERIPH_RESET_N;
    logic [2:0] STATE;
    logic [7:0] LOCK_LOSS_CNT;

    init_reset_sequencer #(
        .LOCK_FILTER   (16),
        .STRETCH_CYCLES(64),
        .STAGE_GAP     (8)
    ) dut (
        .CLK             (CLK),
        .RESET_N         (RESET_N),
        .DEVICE_INIT_DONE(DEVICE_INIT_DONE),
        .PLL_LOCK        (PLL_LOCK),
        .FABRIC_RESET_N  (FABRIC_RESET_N),
        .PERIPH_RESET_N  (PERIPH_RESET_N),
        .STATE           (STATE),
        .LOCK_LOSS_CNT   (LOCK_LOSS_CNT)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        string      name;
        int         tag;
        logic [2:0] st;
        logic       fab;
        logic       per;
        logic [7:0] cnt;
    } exp_t;

    exp_t q[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   exp_cnt     = 0;

    task automatic push(input string nm, input int tag, input logic [2:0] s,
                        input logic f, input logic p);
        exp_t e;
        e.name = nm;
        e.tag  = tag;
        e.st   = s;
        e.fab  = f;
        e.per  = p;
        e.cnt  = 8'(exp_cnt);
        q.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic wait_to(input int tag);
        while (cyc < tag) step(1);
    endtask

    // base: edge count just before the first edge that samples the inputs
    // high. via_init: the init synchroniser also has to fill, which costs
    // one extra edge in WAIT_INIT before the lock filter starts.
    task automatic push_release(input int base, input bit via_init);
        int o;
        o = via_init ? 1 : 0;
        if (via_init) begin
            push("init_wait", base + 2, 3'd1, 1'b0, 1'b0);
            push("init_done", base + 3, 3'd2, 1'b0, 1'b0);
        end
        push("filter_last", base + o + 17, 3'd2, 1'b0, 1'b0);
        push("stretch_in",  base + o + 18, 3'd3, 1'b0, 1'b0);
        push("stretch_end", base + o + 81, 3'd3, 1'b0, 1'b0);
        push("fab_release", base + o + 82, 3'd4, 1'b1, 1'b0);
        push("gap_end",     base + o + 89, 3'd4, 1'b1, 1'b0);
        push("run",         base + o + 90, 3'd5, 1'b1, 1'b1);
        wait_to(base + o + 90);
    endtask

    // Monitor: compare every due snapshot on the falling edge
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            while (q.size() > 0 && q[0].tag <= cyc) begin
                e = q.pop_front();
                vectors++;
                if (e.tag != cyc || STATE !== e.st || FABRIC_RESET_N !== e.fab ||
                    PERIPH_RESET_N !== e.per || LOCK_LOSS_CNT !== e.cnt) begin
                    miscompares++;
                    $display("FAIL %s @edge %0d (tag %0d): got state=%0d fab=%b per=%b cnt=%0d, want state=%0d fab=%b per=%b cnt=%0d",
                             e.name, cyc, e.tag, STATE, FABRIC_RESET_N, PERIPH_RESET_N,
                             LOCK_LOSS_CNT, e.st, e.fab, e.per, e.cnt);
                end
            end
        end
    end

    // Stimulus
    initial begin
        int t;
        int a;
        RESET_N          = 1'b0;
        DEVICE_INIT_DONE = 1'b1;
        PLL_LOCK         = 1'b0;

        // Power-up: reset values, then release with lock rising once in WAIT_LOCK
        step(5);
        push("por_hold", cyc, 3'd0, 1'b0, 1'b0);
        step(1);
        RESET_N = 1'b1;
        a = cyc;
        push("por_wait_init", a + 1, 3'd1, 1'b0, 1'b0);
        push("por_init_sync", a + 2, 3'd1, 1'b0, 1'b0);
        push("por_wait_lock", a + 3, 3'd2, 1'b0, 1'b0);
        wait_to(a + 3);
        PLL_LOCK = 1'b1;
        push_release(cyc, 1'b0);

        // Lock loss in RUN for three cycles, then full re-release
        t = cyc;
        PLL_LOCK = 1'b0;
        push("loss_pre", t + 2, 3'd5, 1'b1, 1'b1);
        exp_cnt++;
        push("loss_hit", t + 3, 3'd2, 1'b0, 1'b0);
        step(3);
        PLL_LOCK = 1'b1;
        push_release(cyc, 1'b0);

        // Lock filter: one-cycle low every 10 cycles never qualifies
        t = cyc;
        PLL_LOCK = 1'b0;
        exp_cnt++;
        push("to_filter", t + 3, 3'd2, 1'b0, 1'b0);
        step(3);
        for (int i = 0; i < 20; i++) begin
            PLL_LOCK = 1'b1;
            step(9);
            PLL_LOCK = 1'b0;
            push("filter_hold", cyc, 3'd2, 1'b0, 1'b0);
            step(1);
        end
        PLL_LOCK = 1'b1;
        push_release(cyc, 1'b0);

        // Init and lock drop together: init wins, count unchanged
        t = cyc;
        DEVICE_INIT_DONE = 1'b0;
        PLL_LOCK         = 1'b0;
        push("simul_pre", t + 2, 3'd5, 1'b1, 1'b1);
        push("simul_hit", t + 3, 3'd1, 1'b0, 1'b0);
        step(3);
        DEVICE_INIT_DONE = 1'b1;
        PLL_LOCK         = 1'b1;
        push_release(cyc, 1'b1);

        // Saturation: 300 one-cycle lock losses, each from RUN
        for (int i = 0; i < 300; i++) begin
            t = cyc;
            PLL_LOCK = 1'b0;
            push("sat_pre", t + 2, 3'd5, 1'b1, 1'b1);
            exp_cnt = (exp_cnt >= 255) ? 255 : exp_cnt + 1;
            push("sat_hit", t + 3, 3'd2, 1'b0, 1'b0);
            step(1);
            PLL_LOCK = 1'b1;
            wait_to(t + 1 + 90);
        end
        push("sat_run", cyc + 1, 3'd5, 1'b1, 1'b1);
        step(1);

        // Async reset pulse mid-STRETCH clears everything, then restart
        t = cyc;
        PLL_LOCK = 1'b0;
        push("pre_rst_loss", t + 3, 3'd2, 1'b0, 1'b0);
        step(1);
        PLL_LOCK = 1'b1;
        a = cyc;
        push("mid_stretch", a + 40, 3'd3, 1'b0, 1'b0);
        wait_to(a + 41);
        RESET_N = 1'b0;
        exp_cnt = 0;
        push("async_rst", cyc, 3'd0, 1'b0, 1'b0);
        #5;
        RESET_N = 1'b1;
        push_release(cyc, 1'b1);

        step(3);
        if (q.size() != 0) begin
            $display("FAIL pending: got %0d unchecked snapshots, want 0", q.size());
            miscompares += q.size();
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
